// File: rtl/password_pkg.sv
// password_pkg: one-hot state encoding and active-low 7-seg glyphs.
// Glyph bit order is {g,f,e,d,c,b,a}; a 0 lights the segment.
package password_pkg;

  localparam int I_IDLE  = 0;
  localparam int I_CHECK = 1;
  localparam int I_OPEN  = 2;
  localparam int I_FAIL  = 3;
  localparam int I_LOCK  = 4;

  typedef enum logic [4:0] {
    S_IDLE  = 5'b00001,
    S_CHECK = 5'b00010,
    S_OPEN  = 5'b00100,
    S_FAIL  = 5'b01000,
    S_LOCK  = 5'b10000
  } state_t;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_O     = 7'b1000000;
  localparam logic [6:0] SEG_P     = 7'b0001100;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_N     = 7'b0101011;
  localparam logic [6:0] SEG_F     = 7'b0001110;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_I     = 7'b1001111;
  localparam logic [6:0] SEG_L     = 7'b1000111;
  localparam logic [6:0] SEG_C     = 7'b1000110;
  localparam logic [6:0] SEG_S     = 7'b0010010;
  localparam logic [6:0] SEG_T     = 7'b0000111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Two-digit BCD split by repeated subtraction; inputs stay below 100.
  function automatic logic [7:0] bcd2(input logic [6:0] v);
    logic [3:0] t;
    logic [6:0] r;
    t = 4'd0;
    r = v;
    for (int i = 0; i < 9; i++) begin
      if (r >= 7'd10) begin
        r = r - 7'd10;
        t = t + 4'd1;
      end
    end
    return {t, r[3:0]};
  endfunction

endpackage

// File: rtl/seg7_decoder.sv
// seg7_decoder: 4-bit decimal digit to active-low 7-seg pattern.
// Codes above 9 render as a blank digit.
module seg7_decoder
  import password_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    unique case (digit_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/password_lock_ctrl.sv
// password_lock_ctrl: code entry FSM with failed-attempt lockout and 7-seg status.
// Define CODE_CHANGE_EN to allow storing a new code while OPEN.
module password_lock_ctrl
  import password_pkg::*;
#(
  parameter logic [9:0]  DEFAULT_CODE = 10'b1111000000,
  parameter int unsigned MAX_TRIES    = 3,
  parameter int unsigned FAIL_CYCLES  = 50_000_000,
  parameter int unsigned TICK_CYCLES  = 50_000_000,
  parameter int unsigned LOCK_SECS    = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] sw,
  input  logic       enter,
  input  logic       lock_req,
  input  logic       set_code,
  output logic [6:0] d0,
  output logic [6:0] d1,
  output logic [6:0] d2,
  output logic [6:0] d3,
  output logic [6:0] d4,
  output logic [9:0] states,
  output logic       unlocked
);

  localparam int unsigned CMAX =
    (FAIL_CYCLES > TICK_CYCLES) ? FAIL_CYCLES : TICK_CYCLES;
  localparam int CW = $clog2(CMAX + 1);
  localparam logic [CW-1:0] FAIL_LAST = CW'(FAIL_CYCLES - 1);
  localparam logic [CW-1:0] TICK_LAST = CW'(TICK_CYCLES - 1);

  state_t          state_q, state_d;
  logic [2:0]      fail_q, fail_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [6:0]      secs_q, secs_d;
  logic [9:0]      att_q, att_d;
  logic            show_q, show_d;
  logic            enter_q;
  logic            press;
  logic            set_rise;
  logic [9:0]      code_q;
  logic [4:0][6:0] disp_q, disp_d;
  logic [2:0]      rem;
  logic [7:0]      bcd;
  logic [3:0]      dig0_in;
  logic [6:0]      seg_lo, seg_hi;

  assign press = enter & ~enter_q;

`ifdef CODE_CHANGE_EN
  logic       set_q;
  logic [9:0] code_d;

  assign set_rise = set_code & ~set_q;

  always_comb begin
    code_d = code_q;
    if (state_q[I_OPEN] && !lock_req && set_rise) begin
      code_d = sw;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      set_q  <= 1'b0;
      code_q <= DEFAULT_CODE;
    end else begin
      set_q  <= set_code;
      code_q <= code_d;
    end
  end
`else
  logic unused_set;

  assign unused_set = set_code;
  assign set_rise   = 1'b0;
  assign code_q     = DEFAULT_CODE;
`endif

  always_comb begin
    state_d = state_q;
    fail_d  = fail_q;
    cnt_d   = cnt_q;
    secs_d  = secs_q;
    att_d   = att_q;
    show_d  = show_q;
    unique case (1'b1)
      state_q[I_IDLE]: begin
        if (press) begin
          state_d = S_CHECK;
          att_d   = sw;
        end
      end
      state_q[I_CHECK]: begin
        cnt_d = '0;
        if (att_q == code_q) begin
          state_d = S_OPEN;
          fail_d  = '0;
        end else begin
          fail_d = fail_q + 3'd1;
          if (fail_d == 3'(MAX_TRIES)) begin
            state_d = S_LOCK;
            secs_d  = 7'(LOCK_SECS);
          end else begin
            state_d = S_FAIL;
          end
        end
      end
      state_q[I_OPEN]: begin
        if (lock_req) begin
          state_d = S_IDLE;
          show_d  = 1'b0;
          cnt_d   = '0;
        end else if (set_rise) begin
          show_d = 1'b1;
          cnt_d  = '0;
        end else if (show_q) begin
          if (cnt_q == FAIL_LAST) begin
            show_d = 1'b0;
            cnt_d  = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      state_q[I_FAIL]: begin
        if (cnt_q == FAIL_LAST) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      state_q[I_LOCK]: begin
        if (cnt_q == TICK_LAST) begin
          cnt_d = '0;
          // Last second expired: release and forgive past failures.
          if (secs_q <= 7'd1) begin
            state_d = S_IDLE;
            fail_d  = '0;
            secs_d  = '0;
          end else begin
            secs_d = secs_q - 7'd1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign rem     = 3'(MAX_TRIES) - fail_q;
  assign bcd     = bcd2(secs_q);
  assign dig0_in = state_q[I_FAIL] ? {1'b0, rem} : bcd[3:0];

  seg7_decoder u_dec_lo (
    .digit_i (dig0_in),
    .seg_o   (seg_lo)
  );

  seg7_decoder u_dec_hi (
    .digit_i (bcd[7:4]),
    .seg_o   (seg_hi)
  );

  always_comb begin
    disp_d = {5{SEG_DASH}};
    unique case (1'b1)
      state_q[I_OPEN]: begin
        if (show_q) begin
          disp_d = {SEG_S, SEG_E, SEG_T, SEG_BLANK, SEG_BLANK};
        end else begin
          disp_d = {SEG_BLANK, SEG_O, SEG_P, SEG_E, SEG_N};
        end
      end
      state_q[I_FAIL]: begin
        disp_d = {SEG_F, SEG_A, SEG_I, SEG_L, seg_lo};
      end
      state_q[I_LOCK]: begin
        disp_d = {SEG_L, SEG_O, SEG_C, seg_hi, seg_lo};
      end
      default: begin
        disp_d = {5{SEG_DASH}};
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      fail_q  <= '0;
      cnt_q   <= '0;
      secs_q  <= '0;
      att_q   <= '0;
      show_q  <= 1'b0;
      enter_q <= 1'b0;
      disp_q  <= {5{SEG_DASH}};
    end else begin
      state_q <= state_d;
      fail_q  <= fail_d;
      cnt_q   <= cnt_d;
      secs_q  <= secs_d;
      att_q   <= att_d;
      show_q  <= show_d;
      enter_q <= enter;
      disp_q  <= disp_d;
    end
  end

  assign d4       = disp_q[4];
  assign d3       = disp_q[3];
  assign d2       = disp_q[2];
  assign d1       = disp_q[1];
  assign d0       = disp_q[0];
  assign states   = {2'b00, fail_q, state_q};
  assign unlocked = state_q[I_OPEN];

endmodule

// File: tb/tb_password_lock_ctrl.sv
// tb_password_lock_ctrl: directed scenarios, then random attempts
// scored against a per-attempt outcome model of the lock rules.
module tb_password_lock_ctrl;

  localparam logic [9:0] DEF  = 10'b1111000000;
  localparam logic [9:0] NEWC = 10'b0000010000;
  localparam logic [9:0] BAD  = 10'b1000000000;
  localparam int MT = 3;
  localparam int FC = 4;
  localparam int TC = 4;
  localparam int LS = 3;

  localparam logic [4:0] ST_IDLE  = 5'b00001;
  localparam logic [4:0] ST_CHECK = 5'b00010;
  localparam logic [4:0] ST_OPEN  = 5'b00100;
  localparam logic [4:0] ST_FAIL  = 5'b01000;
  localparam logic [4:0] ST_LOCK  = 5'b10000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] sw = '0;
  logic       enter = 1'b0;
  logic       lock_req = 1'b0;
  logic       set_code = 1'b0;
  logic [6:0] d0, d1, d2, d3, d4;
  logic [9:0] states;
  logic       unlocked;

  int n_cmp = 0;
  int n_bad = 0;
  int m_fail;
  int n_chk;
  int hold;
  int dur;
  logic [9:0] m_code;
  logic [9:0] a;
  bit good;

  password_lock_ctrl #(
    .DEFAULT_CODE (DEF),
    .MAX_TRIES    (MT),
    .FAIL_CYCLES  (FC),
    .TICK_CYCLES  (TC),
    .LOCK_SECS    (LS)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .sw       (sw),
    .enter    (enter),
    .lock_req (lock_req),
    .set_code (set_code),
    .d0       (d0),
    .d1       (d1),
    .d2       (d2),
    .d3       (d3),
    .d4       (d4),
    .states   (states),
    .unlocked (unlocked)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] gl(input byte c);
    case (c)
      "0": return 7'h40;
      "1": return 7'h79;
      "2": return 7'h24;
      "3": return 7'h30;
      "4": return 7'h19;
      "5": return 7'h12;
      "6": return 7'h02;
      "7": return 7'h78;
      "8": return 7'h00;
      "9": return 7'h10;
      "-": return 7'h3F;
      "O": return 7'h40;
      "P": return 7'h0C;
      "E": return 7'h06;
      "n": return 7'h2B;
      "F": return 7'h0E;
      "A": return 7'h08;
      "I": return 7'h4F;
      "L": return 7'h47;
      "C": return 7'h46;
      "S": return 7'h12;
      "t": return 7'h07;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic logic [34:0] txt(input string s);
    logic [34:0] r;
    r = '0;
    for (int i = 0; i < 5; i++) begin
      r = {r[27:0], gl(s[i])};
    end
    return r;
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_st(input string tag, input int f,
                        input logic [4:0] st);
    chk(tag, 64'({unlocked, states}),
        64'({st == ST_OPEN, 2'b00, 3'(f), st}));
  endtask

  task automatic chk_d(input string tag, input string s);
    chk(tag, 64'({d4, d3, d2, d1, d0}), 64'(txt(s)));
  endtask

  // Leaves the bench just after the edge that registers CHECK.
  task automatic press(input logic [9:0] code);
    sw    = code;
    enter = 1'b0;
    step(1);
    enter = 1'b1;
    step(1);
    enter = 1'b0;
  endtask

  task automatic relock();
    lock_req = 1'b1;
    step(1);
    lock_req = 1'b0;
  endtask

  initial begin
    step(2);
    chk_st("reset_state", 0, ST_IDLE);
    chk_d("reset_disp", "-----");
    rst = 1'b0;

    press(DEF);
    chk_st("t1_check", 0, ST_CHECK);
    step(1);
    chk_st("t1_open", 0, ST_OPEN);
    step(1);
    chk_d("t1_disp", " OPEn");
    relock();
    chk_st("t1_relock", 0, ST_IDLE);

    press(BAD);
    step(1);
    chk_st("t2_fail1", 1, ST_FAIL);
    step(1);
    chk_d("t2_disp1", "FAIL2");
    step(3);
    chk_st("t2_idle1", 1, ST_IDLE);
    press(BAD);
    step(1);
    chk_st("t2_fail2", 2, ST_FAIL);
    step(1);
    chk_d("t2_disp2", "FAIL1");
    step(3);

    press(BAD);
    step(1);
    chk_st("t3_lock", 3, ST_LOCK);
    step(1);
    chk_d("t3_loc03", "LOC03");
    press(DEF);
    chk_st("t3_press_ign", 3, ST_LOCK);
    step(2);
    chk_d("t3_loc02", "LOC02");
    step(4);
    chk_d("t3_loc01", "LOC01");
    step(3);
    chk_st("t3_release", 0, ST_IDLE);
    step(1);
    chk_d("t3_disp_idle", "-----");

    sw    = DEF;
    enter = 1'b0;
    step(1);
    enter = 1'b1;
    n_chk = 0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (states[1]) n_chk++;
    end
    chk("t4_one_check", 64'(n_chk), 64'd1);
    chk_st("t4_open", 0, ST_OPEN);

    enter = 1'b0;
    step(1);
    sw       = NEWC;
    enter    = 1'b1;
    lock_req = 1'b1;
    set_code = 1'b1;
    step(1);
    chk_st("t5_idle", 0, ST_IDLE);
    enter    = 1'b0;
    lock_req = 1'b0;
    set_code = 1'b0;
    press(NEWC);
    step(1);
    chk_st("t5_new_rejected", 1, ST_FAIL);
    step(4);
    press(DEF);
    step(1);
    chk_st("t5_old_kept", 0, ST_OPEN);
    relock();

    for (int k = 0; k < 2; k++) begin
      press(BAD);
      step(5);
    end
    press(BAD);
    step(1);
    chk_st("t6_lock", 3, ST_LOCK);
    step(5);
    chk_d("t6_secs2", "LOC02");
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk_st("t6_reset", 0, ST_IDLE);
    chk_d("t6_reset_disp", "-----");

`ifdef CODE_CHANGE_EN
    press(DEF);
    step(1);
    sw       = NEWC;
    set_code = 1'b1;
    step(1);
    set_code = 1'b0;
    step(1);
    chk_d("cc_set_disp", "SEt  ");
    chk_st("cc_still_open", 0, ST_OPEN);
    step(3);
    chk_d("cc_set_last", "SEt  ");
    step(1);
    chk_d("cc_back_open", " OPEn");
    relock();
    press(NEWC);
    step(1);
    chk_st("cc_new_opens", 0, ST_OPEN);
    relock();
    press(DEF);
    step(1);
    chk_st("cc_old_fails", 1, ST_FAIL);
    step(4);
`endif

    rst = 1'b1;
    step(1);
    rst    = 1'b0;
    m_fail = 0;
    m_code = DEF;
    for (int t = 0; t < 40; t++) begin
      good = ($urandom_range(0, 1) == 1);
      a    = good ? m_code : 10'($urandom);
      if (!good && a == m_code) a = a ^ 10'd1;
      press(a);
      step(1);
      if (a == m_code) begin
        m_fail = 0;
        chk_st("rnd_open", m_fail, ST_OPEN);
        step(1);
        chk_d("rnd_open_disp", " OPEn");
        hold = $urandom_range(0, 4);
        for (int h = 0; h < hold; h++) begin
          enter = 1'($urandom_range(0, 1));
          step(1);
        end
        enter = 1'b0;
        chk_st("rnd_open_hold", 0, ST_OPEN);
        relock();
        chk_st("rnd_relock", 0, ST_IDLE);
      end else begin
        m_fail++;
        if (m_fail == MT) begin
          chk_st("rnd_lock", m_fail, ST_LOCK);
          step(1);
          chk_d("rnd_lock_disp", $sformatf("LOC%02d", LS));
          dur = LS * TC;
        end else begin
          chk_st("rnd_fail", m_fail, ST_FAIL);
          step(1);
          chk_d("rnd_fail_disp", $sformatf("FAIL%0d", MT - m_fail));
          dur = FC;
        end
        for (int k = 1; k <= dur - 2; k++) begin
          enter = 1'($urandom_range(0, 1));
          step(1);
        end
        enter = 1'b0;
        chk_st("rnd_wait_end", m_fail,
               (m_fail == MT) ? ST_LOCK : ST_FAIL);
        step(1);
        if (m_fail == MT) m_fail = 0;
        chk_st("rnd_back_idle", m_fail, ST_IDLE);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
